// File: rtl/char_history_display.sv
// Shift-register history of received characters shown as pairs of seg7 digits,
// with hold/clear control, overflow flag and a retriggerable "new char" LED.
module char_history_display #(
   parameter int          CHAR_W       = 7,
   parameter int          DEPTH        = 4,
   parameter int          BLINK_CYCLES = 25000000,
   parameter logic [6:0]  BLANK        = 7'h7F
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHAR_W-1:0]     char,
   input  logic                  char_valid,
   output logic                  char_ready,
   input  logic                  hold,
   input  logic                  clear,
   output logic [DEPTH*14-1:0]   disp,
   output logic                  led_new,
   output logic [3:0]            count,
   output logic                  dropped
);

   localparam int BW = $clog2(BLINK_CYCLES + 1);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t              r_state;
   logic [CHAR_W-1:0]   r_slot [DEPTH];
   logic [3:0]          r_count;
   logic                r_dropped;
   logic [BW-1:0]       r_blink;
   logic                w_accept;
   logic [DEPTH*14-1:0] w_disp;

   // Active-low segments, bit order gfedcba, so BLANK = all segments off.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign char_ready = (r_state == RUN) && !clear;
   assign w_accept   = char_valid && char_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= RUN;
         r_count   <= 4'd0;
         r_dropped <= 1'b0;
         r_blink   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_slot[k] <= '0;
         end
      end else begin
         case (r_state)
            RUN:     r_state <= hold ? HOLD : RUN;
            default: r_state <= hold ? HOLD : RUN;
         endcase

         // Clear wins over accept; accept is already masked by char_ready.
         if (clear) begin
            r_count   <= 4'd0;
            r_dropped <= 1'b0;
         end else if (w_accept) begin
            r_slot[0] <= char;
            for (int k = DEPTH - 1; k > 0; k--) begin
               r_slot[k] <= r_slot[k-1];
            end
            if (r_count == 4'(DEPTH)) begin
               r_dropped <= 1'b1;
            end else begin
               r_count <= r_count + 4'd1;
            end
         end

         if (w_accept) begin
            r_blink <= BW'(BLINK_CYCLES);
         end else if (r_blink != '0) begin
            r_blink <= r_blink - BW'(1);
         end
      end
   end

   always_comb begin
      w_disp = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (4'(k) < r_count) begin
            w_disp[14*k +: 14] = {seg7(4'(r_slot[k] >> 4)), seg7(r_slot[k][3:0])};
         end else begin
            w_disp[14*k +: 14] = {BLANK, BLANK};
         end
      end
   end

   assign disp    = w_disp;
   assign count   = r_count;
   assign dropped = r_dropped;
   assign led_new = (r_blink != '0);

endmodule

// File: tb/tb_char_history_display.sv
// Scoreboard bench for char_history_display (CHAR_W=7, DEPTH=4, BLINK_CYCLES=10).
module tb_char_history_display;

   logic        clk = 1'b0;
   logic        rst_n, char_valid, hold, clear;
   logic [6:0]  chr;
   logic        char_ready, led_new, dropped;
   logic [55:0] disp;
   logic [3:0]  count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [55:0] disp;
      logic [3:0]  cnt;
      logic        drp;
      logic        led;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   logic       mHold;
   logic [6:0] mSlot [4];
   logic [3:0] mCount;
   logic       mDropped;
   int         mBlink;
   logic       obsReady, expReady;

   char_history_display #(.CHAR_W(7), .DEPTH(4), .BLINK_CYCLES(10), .BLANK(7'h7F)) dut (
      .clk(clk), .rst_n(rst_n), .char(chr), .char_valid(char_valid),
      .char_ready(char_ready), .hold(hold), .clear(clear), .disp(disp),
      .led_new(led_new), .count(count), .dropped(dropped)
   );

   always #5 clk = ~clk;

   // Active-high hex font; the display is inverted (segments lit low).
   function automatic logic [6:0] hexFont(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic logic [55:0] modelDisp();
      logic [55:0] d;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(mCount))
            d[14*k +: 14] = {~hexFont({1'b0, mSlot[k][6:4]}), ~hexFont(mSlot[k][3:0])};
         else
            d[14*k +: 14] = {7'h7F, 7'h7F};
      end
      return d;
   endfunction

   // Drive one cycle, advance the reference model at the edge, queue its expectation.
   task automatic tick(input logic v, input logic [6:0] c, input logic h, input logic cl, input logic r);
      exp_t x;
      logic acc;
      chr = c; char_valid = v; hold = h; clear = cl; rst_n = r;
      #1;
      obsReady = char_ready;
      expReady = !mHold && !cl;
      @(posedge clk);
      if (!r) begin
         mHold = 1'b0; mCount = 0; mDropped = 1'b0; mBlink = 0;
         for (int k = 0; k < 4; k++) mSlot[k] = 7'h00;
      end else begin
         acc   = v && expReady;
         mHold = h;
         if (cl) begin
            mCount = 0; mDropped = 1'b0;
         end else if (acc) begin
            for (int k = 3; k > 0; k--) mSlot[k] = mSlot[k-1];
            mSlot[0] = c;
            if (mCount == 4) mDropped = 1'b1;
            else mCount = mCount + 1;
         end
         if (acc) mBlink = 10;
         else if (mBlink > 0) mBlink = mBlink - 1;
      end
      x.disp = modelDisp(); x.cnt = mCount; x.drp = mDropped; x.led = (mBlink != 0);
      exp_q.push_back(x);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 7'h55, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         total++;
         if ({disp, count, dropped, led_new} !== {e.disp, e.cnt, e.drp, e.led}) begin
            bad++; $display("[TB] FAIL reset_state: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                            disp, count, dropped, led_new, e.disp, e.cnt, e.drp, e.led);
         end
      end
      total++;
      if (disp !== {8{7'h7F}} || led_new !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_blank: got disp=%h led=%b want all 7F led=0", disp, led_new);
      end
      tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (obsReady !== 1'b1) begin
         bad++; $display("[TB] FAIL ready_after_reset: got %b want 1", obsReady);
      end
   endtask

   task automatic test_single();
      int hi;
      hi = 0;
      tick(1'b1, 7'h41, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (disp !== {{6{7'h7F}}, 7'h19, 7'h79} || count !== 4'd1) begin
         bad++; $display("[TB] FAIL single_0x41: got disp=%h count=%0d want %h count=1",
                         disp, count, {{6{7'h7F}}, 7'h19, 7'h79});
      end
      if (led_new === 1'b1) hi++;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         total++;
         if ({disp, count, dropped, led_new} !== {e.disp, e.cnt, e.drp, e.led}) begin
            bad++; $display("[TB] FAIL single_idle: got %h/%0d/%b want %h/%0d/%b",
                            disp, count, led_new, e.disp, e.cnt, e.led);
         end
         if (led_new !== 1'b1) break;
         hi++;
      end
      total++;
      if (hi != 10) begin
         bad++; $display("[TB] FAIL blink_len: got %0d want 10", hi);
      end
   endtask

   task automatic test_overflow();
      tick(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
      e = exp_q.pop_front();
      for (int i = 1; i <= 5; i++) begin
         tick(1'b1, 7'(i), 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         total++;
         if ({disp, count, dropped, led_new} !== {e.disp, e.cnt, e.drp, e.led}) begin
            bad++; $display("[TB] FAIL overflow_step%0d: got %h/%0d/%b want %h/%0d/%b",
                            i, disp, count, dropped, e.disp, e.cnt, e.drp);
         end
      end
      total++;
      if (disp !== {7'h40, 7'h24, 7'h40, 7'h30, 7'h40, 7'h19, 7'h40, 7'h12}
          || count !== 4'd4 || dropped !== 1'b1) begin
         bad++; $display("[TB] FAIL overflow_final: got disp=%h count=%0d dropped=%b want slots 05,04,03,02 count=4 dropped=1",
                         disp, count, dropped);
      end
   endtask

   task automatic test_hold();
      logic [55:0] frozen;
      logic [3:0]  want;
      tick(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
      e = exp_q.pop_front();
      tick(1'b1, 7'h2A, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 7'h30 + 7'(i), (i < 3), 1'b0, 1'b1);
         e = exp_q.pop_front();
         if (i == 0) frozen = disp;
         total++;
         if (obsReady !== expReady) begin
            bad++; $display("[TB] FAIL hold_ready%0d: got %b want %b", i, obsReady, expReady);
         end
         total++;
         if ({disp, count, dropped, led_new} !== {e.disp, e.cnt, e.drp, e.led}) begin
            bad++; $display("[TB] FAIL hold_data%0d: got %h/%0d want %h/%0d", i, disp, count, e.disp, e.cnt);
         end
         if (i >= 1 && i <= 3) begin
            total++;
            if (disp !== frozen) begin
               bad++; $display("[TB] FAIL hold_frozen%0d: got %h want %h", i, disp, frozen);
            end
         end
      end
      want = 4'd3;
      total++;
      if (count !== want) begin
         bad++; $display("[TB] FAIL hold_resume: got count=%0d want %0d", count, want);
      end
   endtask

   task automatic test_clear();
      tick(1'b1, 7'h11, 1'b0, 1'b1, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (obsReady !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_ready: got %b want 0", obsReady);
      end
      total++;
      if (disp !== {8{7'h7F}} || count !== 4'd0 || dropped !== 1'b0) begin
         bad++; $display("[TB] FAIL clear_state: got disp=%h count=%0d dropped=%b want blank/0/0",
                         disp, count, dropped);
      end
   endtask

   task automatic test_retrigger();
      int hi;
      bit gap;
      for (int i = 0; i < 15; i++) begin
         tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
      end
      hi = 0; gap = 0;
      tick(1'b1, 7'h61, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         if (led_new !== 1'b1) gap = 1;
      end
      tick(1'b1, 7'h62, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      if (led_new === 1'b1) hi++; else gap = 1;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
         total++;
         if (led_new !== e.led) begin
            bad++; $display("[TB] FAIL retrig_led%0d: got %b want %b", i, led_new, e.led);
         end
         if (led_new !== 1'b1) break;
         hi++;
      end
      total++;
      if (gap || hi != 10) begin
         bad++; $display("[TB] FAIL retrigger: got gap=%0d high=%0d want gap=0 high=10", gap, hi);
      end
   endtask

   task automatic test_reset_hold();
      tick(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 7'h70 + 7'(i), 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
      end
      tick(1'b0, 7'h00, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front();
      tick(1'b1, 7'h7E, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (disp !== {8{7'h7F}} || count !== 4'd0 || led_new !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_in_hold: got disp=%h count=%0d led=%b want blank/0/0",
                         disp, count, led_new);
      end
      tick(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (obsReady !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_to_run: got ready=%b want 1", obsReady);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         tick(1'($urandom_range(0, 3) != 0), 7'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 15) == 0), 1'b1);
         e = exp_q.pop_front();
         total++;
         if (obsReady !== expReady) begin
            bad++; $display("[TB] FAIL b2b_ready%0d: got %b want %b", i, obsReady, expReady);
         end
         total++;
         if ({disp, count, dropped, led_new} !== {e.disp, e.cnt, e.drp, e.led}) begin
            bad++; $display("[TB] FAIL b2b_data%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                            i, disp, count, dropped, led_new, e.disp, e.cnt, e.drp, e.led);
         end
      end
   endtask

   initial begin
      mHold = 1'b0; mCount = 0; mDropped = 1'b0; mBlink = 0;
      for (int k = 0; k < 4; k++) mSlot[k] = 7'h00;
      test_reset();
      test_single();
      test_overflow();
      test_hold();
      test_clear();
      test_retrigger();
      test_reset_hold();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
